// File: rtl/noc_types_pkg.sv
// Shared NoC flit types and the node port used by both ends of the serial link.
// Keeping the flit width here means transmitter and receiver cannot disagree.
package noc_types;
    localparam int FLIT_DATA_BITS = 8;
    typedef logic [FLIT_DATA_BITS-1:0] flit_data_t;
endpackage

// File: rtl/node_port.sv
// Flit-level valid/ready link between two NoC nodes.
interface node_port;
    import noc_types::*;
    flit_data_t data;
    logic       valid;
    logic       last;
    logic       ready;
    modport up   (output data, output valid, output last, input ready);
    modport down (input data, input valid, input last, output ready);
endinterface

// File: rtl/noc_serial_transmitter.sv
// Serialises one packet into LSB-first flits on a node_port up link.
// One packet in flight; after it completes, a flush re-arms the sender.
module noc_serial_transmitter
    import noc_types::*;
#(
    parameter int PACKET_BITS    = 32,
    parameter int FLIT_DATA_BITS = noc_types::FLIT_DATA_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   send,
    input  logic [PACKET_BITS-1:0] packet,
    output logic                   ready,
    output logic                   busy,
    node_port.up                   up
);
    localparam int NUM_FLITS  = (PACKET_BITS + FLIT_DATA_BITS - 1) / FLIT_DATA_BITS;
    localparam int SHIFT_BITS = NUM_FLITS * FLIT_DATA_BITS;
    localparam int CNT_BITS   = $clog2(NUM_FLITS + 1);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NUM_FLITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [SHIFT_BITS-1:0] shift_q, shift_d;
    logic [CNT_BITS-1:0]   flit_cnt_q, flit_cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  xfer;

    assign xfer = valid_q & up.ready;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        flit_cnt_d   = flit_cnt_q;
        flush_pend_d = flush_pend_q;
        unique case (state_q)
            IDLE: begin
                if (send) begin
                    // zero-extension places the pad bits in the MSBs of the last flit
                    shift_d    = SHIFT_BITS'(packet);
                    flit_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                flush_pend_d = flush_pend_q | flush;
                if (xfer) begin
                    shift_d    = shift_q >> FLIT_DATA_BITS;
                    flit_cnt_d = flit_cnt_q + CNT_BITS'(1);
                    if (flit_cnt_q == LAST_CNT) begin
                        state_d      = (flush_pend_q | flush) ? IDLE : DONE;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (flush) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == SEND);
        last_d  = (state_d == SEND) && (flit_cnt_d == LAST_CNT);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            flit_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            flit_cnt_q   <= flit_cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign up.data  = shift_q[FLIT_DATA_BITS-1:0];
    assign up.valid = valid_q;
    assign up.last  = last_q;
    assign ready    = ready_q;
    assign busy     = busy_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (valid_q && !up.ready) |=> (valid_q && $stable(up.data) && $stable(up.last)));

    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == SEND) |-> (flit_cnt_q < CNT_BITS'(NUM_FLITS)));
endmodule

// File: tb/tb_noc_serial_transmitter.sv
// Directed bench for noc_serial_transmitter: 32-bit and 12-bit packet instances.
// Each scenario task drives stimulus on the falling edge and checks outputs there.
module tb_noc_serial_transmitter;
    import noc_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        send = 1'b0;
    logic        send12 = 1'b0;
    logic [31:0] pkt32 = '0;
    logic [11:0] pkt12 = '0;
    logic        rdy32, busy32, rdy12, busy12;
    int          checks = 0;
    int          errors = 0;

    node_port p32 ();
    node_port p12 ();

    always #5 clk = ~clk;

    noc_serial_transmitter #(.PACKET_BITS(32), .FLIT_DATA_BITS(8)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .send(send), .packet(pkt32),
        .ready(rdy32), .busy(busy32), .up(p32.up)
    );

    noc_serial_transmitter #(.PACKET_BITS(12), .FLIT_DATA_BITS(8)) u12 (
        .clk(clk), .rst(rst), .flush(flush), .send(send12), .packet(pkt12),
        .ready(rdy12), .busy(busy12), .up(p12.up)
    );

    task automatic test_reset();
        p32.ready = 1'b1;
        p12.ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (p32.valid !== 1'b0 || p32.last !== 1'b0 || p32.data !== 8'h00 ||
            rdy32 !== 1'b1 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL reset32: valid=%b last=%b data=%h ready=%b busy=%b want 0 0 00 1 0",
                     p32.valid, p32.last, p32.data, rdy32, busy32);
        end
        checks++;
        if (p12.valid !== 1'b0 || p12.data !== 8'h00 || rdy12 !== 1'b1 || busy12 !== 1'b0) begin
            errors++;
            $display("FAIL reset12: valid=%b data=%h ready=%b busy=%b want 0 00 1 0",
                     p12.valid, p12.data, rdy12, busy12);
        end
        rst = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (rdy32 !== 1'b1 || p32.valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush: ready=%b valid=%b want 1 0", rdy32, p32.valid);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pkt32 = 32'hDEADBEEF;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        pkt32 = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (p32.valid !== 1'b1 || p32.data !== exp[i] || p32.last !== (i == 3) ||
                busy32 !== 1'b1 || rdy32 !== 1'b0) begin
                errors++;
                $display("FAIL basic_flit%0d: valid=%b data=%h last=%b busy=%b ready=%b want 1 %h %b 1 0",
                         i, p32.valid, p32.data, p32.last, busy32, rdy32, exp[i], i == 3);
            end
            @(negedge clk);
        end
        checks++;
        if (p32.valid !== 1'b0 || rdy32 !== 1'b0 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: valid=%b ready=%b busy=%b want 0 0 0",
                     p32.valid, rdy32, busy32);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (rdy32 !== 1'b1) begin
            errors++;
            $display("FAIL basic_rearm: ready=%b want 1", rdy32);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pkt32 = 32'hDEADBEEF;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                p32.ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (p32.valid !== 1'b1 || p32.data !== 8'hAD || p32.last !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold%0d: valid=%b data=%h last=%b want 1 ad 0",
                                 k, p32.valid, p32.data, p32.last);
                    end
                    @(negedge clk);
                end
                p32.ready = 1'b1;
            end
            checks++;
            if (p32.valid !== 1'b1 || p32.data !== exp[i] || p32.last !== (i == 3)) begin
                errors++;
                $display("FAIL stall_flit%0d: valid=%b data=%h last=%b want 1 %h %b",
                         i, p32.valid, p32.data, p32.last, exp[i], i == 3);
            end
            @(negedge clk);
        end
        checks++;
        if (p32.valid !== 1'b0 || rdy32 !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: valid=%b ready=%b want 0 0", p32.valid, rdy32);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_pad12();
        logic [7:0] exp [2] = '{8'hBC, 8'h0A};
        pkt12 = 12'hABC;
        send12 = 1'b1;
        @(negedge clk);
        send12 = 1'b0;
        pkt12 = 12'hFFF;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (p12.valid !== 1'b1 || p12.data !== exp[i] || p12.last !== (i == 1)) begin
                errors++;
                $display("FAIL pad12_flit%0d: valid=%b data=%h last=%b want 1 %h %b",
                         i, p12.valid, p12.data, p12.last, exp[i], i == 1);
            end
            @(negedge clk);
        end
        checks++;
        if (p12.valid !== 1'b0 || rdy12 !== 1'b0) begin
            errors++;
            $display("FAIL pad12_done: valid=%b ready=%b want 0 0", p12.valid, rdy12);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_no_rearm();
        logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        pkt32 = 32'h11223344;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (4) @(negedge clk);
        pkt32 = 32'h12345678;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        checks++;
        if (rdy32 !== 1'b0 || p32.valid !== 1'b0 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL norearm_ignored: ready=%b valid=%b busy=%b want 0 0 0",
                     rdy32, p32.valid, busy32);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (rdy32 !== 1'b1) begin
            errors++;
            $display("FAIL norearm_flush: ready=%b want 1", rdy32);
        end
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (p32.valid !== 1'b1 || p32.data !== exp[i] || p32.last !== (i == 3)) begin
                errors++;
                $display("FAIL norearm_flit%0d: valid=%b data=%h last=%b want 1 %h %b",
                         i, p32.valid, p32.data, p32.last, exp[i], i == 3);
            end
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_flush_pend(input int at);
        logic [7:0] exp [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        pkt32 = 32'hCAFEF00D;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush = (i == at);
            checks++;
            if (p32.valid !== 1'b1 || p32.data !== exp[i] || p32.last !== (i == 3)) begin
                errors++;
                $display("FAIL flushpend%0d_flit%0d: valid=%b data=%h last=%b want 1 %h %b",
                         at, i, p32.valid, p32.data, p32.last, exp[i], i == 3);
            end
            @(negedge clk);
        end
        flush = 1'b0;
        checks++;
        if (rdy32 !== 1'b1 || p32.valid !== 1'b0 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL flushpend%0d_idle: ready=%b valid=%b busy=%b want 1 0 0",
                     at, rdy32, p32.valid, busy32);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
        pkt32 = 32'h55667788;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        @(negedge clk);
        checks++;
        if (p32.valid !== 1'b1 || p32.data !== 8'h77) begin
            errors++;
            $display("FAIL midrst_flit1: valid=%b data=%h want 1 77", p32.valid, p32.data);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (p32.valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: valid=%b want 0", p32.valid);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy32 !== 1'b1 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: ready=%b busy=%b want 1 0", rdy32, busy32);
        end
        pkt32 = 32'h0000_0001;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (p32.valid !== 1'b1 || p32.data !== exp[i] || p32.last !== (i == 3)) begin
                errors++;
                $display("FAIL midrst_flit%0d: valid=%b data=%h last=%b want 1 %h %b",
                         i, p32.valid, p32.data, p32.last, exp[i], i == 3);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        p32.ready = 1'b1;
        p12.ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_pad12();
        test_no_rearm();
        test_flush_pend(2);
        test_flush_pend(3);
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
